breadboard_class_rx: RTL
========================

# breadboard_class_rx

Receive side of the breadboard class link. The classifier board drives a 3-bit active-low class code onto its breadboard pins: rock = 3'b011, paper = 3'b101, scissors = 3'b110, none = 3'b111. This block sits on the observing board and does four things:
- synchronizes and debounces those pins;
- decodes them back into the one-hot class encoding used by the switch inputs (rock = 3'b001, paper = 3'b010, scissors = 3'b100);
- emits a one-cycle pulse per new class;
- keeps per-class hit counters, shown on the 6 board LEDs.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 50000, cycles a synchronized code must stay unchanged before commit (1 ms at 50 MHz); legal range >= 1.

Ports:
- fpga_clk  input  1  system clock, 50 MHz.
- rst  input  1  reset, synchronous, active-high.
- breadboard_in  input  3  asynchronous active-low class code from the classifier board.
- class_onehot  output  3  committed class; 3'b001 rock, 3'b010 paper, 3'b100 scissors, 3'b000 none.
- class_valid  output  1  one-cycle pulse when a new legal class commits.
- LED  output  6  hit counters: LED[1:0] rock, LED[3:2] paper, LED[5:4] scissors.
- error  output  1  sticky illegal-code flag (see Configuration).

## Operation
- **Synchronizer:** two flops, sync1 then sync2; both reset to 3'b111.
- **Debounce registers:**
  - cand (3b, reset 3'b111), counter cnt (width $clog2(DEBOUNCE_CYCLES)+1, reset 0), committed code stable (reset 3'b111).
  - If sync2 != cand: cand <= sync2, cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt increments.
  - Else (cnt == DEBOUNCE_CYCLES-1): cnt holds. If cand != stable, commit: stable <= cand.
- **Decode on commit (registered, same edge as stable update):**
  - 011/101/110: class_onehot <= 001/010/100, class_valid <= 1, matching 2-bit counter increments modulo 4 (3 -> 0 wraps silently).
  - 111: class_onehot <= 000, no pulse, no counter change.
  - 000/001/010/100 (illegal): handled per Configuration.
- **Outside a commit:** class_valid = 0 and class_onehot holds.
- **Glitches:** a code shorter than DEBOUNCE_CYCLES synchronized cycles never commits. A glitch that returns to the committed code produces no pulse.
- **Direct class change** (e.g. 011 -> 101 with no idle in between): commits and pulses normally.
- **Same class repeated** after an idle commit: pulses again and counts again.
- **Reset:** rst asserted mid-debounce or mid-commit clears everything to reset values on that edge. Reset values: class_onehot = 0, class_valid = 0, LED = 0, error = 0.

## Timing
- Input change lands between edge 0 and edge 1. Then:
  - sync1 captures at edge 1, sync2 at edge 2;
  - cand loads at edge 3 with cnt = 0;
  - commit and outputs update at edge DEBOUNCE_CYCLES+3.
- Latency is DEBOUNCE_CYCLES+3 cycles. With DEBOUNCE_CYCLES = 1, latency is 4.
- class_valid is high for exactly one cycle per commit. Consecutive commits are at least DEBOUNCE_CYCLES+1 cycles apart.
- All outputs are registered; there are no combinational paths from breadboard_in.

## Configuration
- Macro: BREADBOARD_RX_ERR_EN.
- **Defined:** committing an illegal code sets error = 1 (sticky until rst) and class_onehot <= 000. No pulse, no counter change.
- **Not defined:**
  - the error port still exists, tied 0;
  - illegal codes are treated exactly as 3'b111 (class_onehot <= 000, no pulse).

## Test plan
DEBOUNCE_CYCLES = 4 unless noted.
- **Reset then hold:** rst 2 cycles, hold 111 -> class_onehot = 000, LED = 0, class_valid never high, error = 0.
- **Single class:** drive 011 from idle -> class_valid pulses once at edge 7 after the change, class_onehot = 001, LED = 6'b000001.
- **Glitch rejection:** from idle, drive 101 for 3 cycles then back to 111 -> no pulse, outputs unchanged. Then hold 101 for 10 cycles -> one pulse, class_onehot = 010, LED[3:2] = 1.
- **Wrap and direct change:** alternate 110/111 five times with >= 8 cycles each -> five pulses, LED[5:4] = 1 after wrap. Then 110 -> 011 directly -> pulse, class_onehot = 001.
- **Illegal code:** hold 000 for 10 cycles.
  - With BREADBOARD_RX_ERR_EN: error = 1 and stays 1 after return to 011 (which still pulses); rst clears it.
  - Without the macro: error = 0, class_onehot = 000, no pulse.
- **Reset mid-debounce:** drive 011, assert rst at cycle 5 after the change, hold 011 -> pulse occurs 7 cycles after rst deasserts, LED = 6'b000001.

Source files
------------

// File: rtl/breadboard_class_rx.sv
// Sync, debounce and decode of the active-low breadboard class code into one-hot, pulse and LED hit counters.
// Latency DEBOUNCE_CYCLES+3 cycles, no backpressure; define BREADBOARD_RX_ERR_EN for the sticky illegal-code flag.
module breadboard_class_rx #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       fpga_clk,
  input  logic       rst,
  input  logic [2:0] breadboard_in,
  output logic [2:0] class_onehot,
  output logic       class_valid,
  output logic [5:0] LED,
  output logic       error
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] CODE_ROCK     = 3'b011;
  localparam logic [2:0] CODE_PAPER    = 3'b101;
  localparam logic [2:0] CODE_SCISSORS = 3'b110;
  localparam logic [2:0] CODE_NONE     = 3'b111;

  logic [2:0]    sync1, sync2, cand, stable;
  logic [CW-1:0] cnt;
  logic [1:0]    rock_hits, paper_hits, scissors_hits;
  logic          commit;

  // A commit happens once the candidate has been stable long enough and differs from the last commit.
  assign commit = (sync2 == cand) && (cnt == CNT_MAX) && (cand != stable);

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      sync1         <= CODE_NONE;
      sync2         <= CODE_NONE;
      cand          <= CODE_NONE;
      stable        <= CODE_NONE;
      cnt           <= '0;
      class_onehot  <= 3'b000;
      class_valid   <= 1'b0;
      rock_hits     <= 2'd0;
      paper_hits    <= 2'd0;
      scissors_hits <= 2'd0;
    end else begin
      sync1       <= breadboard_in;
      sync2       <= sync1;
      class_valid <= 1'b0;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt < CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end
      if (commit) begin
        stable <= cand;
        case (cand)
          CODE_ROCK: begin
            class_onehot <= 3'b001;
            class_valid  <= 1'b1;
            rock_hits    <= rock_hits + 2'd1;
          end
          CODE_PAPER: begin
            class_onehot <= 3'b010;
            class_valid  <= 1'b1;
            paper_hits   <= paper_hits + 2'd1;
          end
          CODE_SCISSORS: begin
            class_onehot  <= 3'b100;
            class_valid   <= 1'b1;
            scissors_hits <= scissors_hits + 2'd1;
          end
          default: class_onehot <= 3'b000;
        endcase
      end
    end
  end

  assign LED = {scissors_hits, paper_hits, rock_hits};

`ifdef BREADBOARD_RX_ERR_EN
  logic err_q;

  always_ff @(posedge fpga_clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (commit && (cand != CODE_ROCK) && (cand != CODE_PAPER) &&
                 (cand != CODE_SCISSORS) && (cand != CODE_NONE)) begin
      err_q <= 1'b1;
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule
